// File: rtl/if_pipe_ctrl_if.sv
// if_pipe_ctrl_if -- bundle between the front-end pipeline sequencer and its
// neighbours (hazard unit, EXE, MEM, IF stage, IF/ID and ID/EX registers).
//
// Signals:
//   mem_stall         MEM stage busy; freeze the whole front end
//   branch_req        single-cycle taken-branch pulse from EXE
//   branch_target     branch target, valid with branch_req
//   hazard_detected   level from ID: data hazard on the instruction in ID
//   pc_freeze         to IF freeze
//   pc_branch_taken   to IF branch_taken
//   pc_branch_addr    to IF branch_addr (0 when not taken)
//   if_id_freeze      hold IF/ID
//   if_id_flush       clear IF/ID to NOP
//   id_ex_flush       clear ID/EX to NOP
//   stall_timeout     sticky: hazard stall ran too long
//   branch_ovf        sticky: a pending branch was overwritten
//   perf_stall_cycles cycles with pc_freeze=1
//   perf_flushes      redirects issued
//
// Modports: master = event sources / consumers side, slave = sequencer.
interface if_pipe_ctrl_if;
  logic        mem_stall;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        hazard_detected;
  logic        pc_freeze;
  logic        pc_branch_taken;
  logic [31:0] pc_branch_addr;
  logic        if_id_freeze;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        stall_timeout;
  logic        branch_ovf;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;

  modport master (
    output mem_stall, branch_req, branch_target, hazard_detected,
    input  pc_freeze, pc_branch_taken, pc_branch_addr, if_id_freeze,
           if_id_flush, id_ex_flush, stall_timeout, branch_ovf,
           perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  mem_stall, branch_req, branch_target, hazard_detected,
    output pc_freeze, pc_branch_taken, pc_branch_addr, if_id_freeze,
           if_id_flush, id_ex_flush, stall_timeout, branch_ovf,
           perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/if_pipe_ctrl.sv
// if_pipe_ctrl -- front-end pipeline sequencer.
//
// Arbitrates MEM stalls, EXE branch redirects and ID data hazards into the
// IF-stage and pipeline-register controls. A branch arriving during a MEM
// stall is held and replayed in the first unstalled cycle.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset; forces every output to 0
//   bus  if_pipe_ctrl_if.slave (see interface file for the signal list)
//
// Parameter:
//   MAX_HAZ_STALL  consecutive hazard-stall cycles (1..65535) at which
//                  stall_timeout sets
//
// Optional feature macro: IF_PIPE_CTRL_PERF_EN
//   defined   -> perf_stall_cycles / perf_flushes count
//   undefined -> both perf ports tied to 0
module if_pipe_ctrl #(
  parameter int unsigned MAX_HAZ_STALL = 15
) (
  input logic          clk,
  input logic          rst,
  if_pipe_ctrl_if.slave bus
);

  localparam logic [15:0] HAZ_LIMIT = 16'(MAX_HAZ_STALL);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT, HAZ_STALL} mode_t;

  mode_t       mode;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [15:0] haz_cnt;
  logic [15:0] haz_inc;
  logic        stall_timeout_r;
  logic        branch_ovf_r;
  logic        br;
  logic [31:0] br_addr;

  // Cycle classification; a live branch request takes precedence over a
  // pending one, and MEM stall outranks everything.
  always_comb begin
    br      = bus.branch_req | pend_valid;
    br_addr = bus.branch_req ? bus.branch_target : pend_addr;
    haz_inc = (haz_cnt == 16'hFFFF) ? haz_cnt : haz_cnt + 16'd1;
    mode    = RUN;
    if (bus.mem_stall)            mode = MEM_WAIT;
    else if (br)                  mode = REDIRECT;
    else if (bus.hazard_detected) mode = HAZ_STALL;
  end

  // Control outputs are forced low for the whole time rst is high.
  always_comb begin
    bus.pc_freeze       = 1'b0;
    bus.pc_branch_taken = 1'b0;
    bus.pc_branch_addr  = '0;
    bus.if_id_freeze    = 1'b0;
    bus.if_id_flush     = 1'b0;
    bus.id_ex_flush     = 1'b0;
    if (!rst) begin
      case (mode)
        MEM_WAIT: begin
          bus.pc_freeze    = 1'b1;
          bus.if_id_freeze = 1'b1;
        end
        REDIRECT: begin
          bus.pc_branch_taken = 1'b1;
          bus.pc_branch_addr  = br_addr;
          bus.if_id_flush     = 1'b1;
          bus.id_ex_flush     = 1'b1;
        end
        HAZ_STALL: begin
          bus.pc_freeze    = 1'b1;
          bus.if_id_freeze = 1'b1;
          bus.id_ex_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid      <= 1'b0;
      pend_addr       <= '0;
      haz_cnt         <= '0;
      stall_timeout_r <= 1'b0;
      branch_ovf_r    <= 1'b0;
    end else begin
      case (mode)
        MEM_WAIT: begin
          // haz_cnt deliberately holds so a hazard split by a MEM stall
          // still accumulates toward the timeout.
          if (bus.branch_req) begin
            pend_valid <= 1'b1;
            pend_addr  <= bus.branch_target;
            if (pend_valid) branch_ovf_r <= 1'b1;
          end
        end
        REDIRECT: begin
          pend_valid <= 1'b0;
          haz_cnt    <= '0;
        end
        HAZ_STALL: begin
          haz_cnt <= haz_inc;
          if (haz_inc == HAZ_LIMIT) stall_timeout_r <= 1'b1;
        end
        default: haz_cnt <= '0;
      endcase
    end
  end

  assign bus.stall_timeout = stall_timeout_r;
  assign bus.branch_ovf    = branch_ovf_r;

`ifdef IF_PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mode == MEM_WAIT || mode == HAZ_STALL) stall_cnt <= stall_cnt + 32'd1;
      if (mode == REDIRECT)                      flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = stall_cnt;
  assign bus.perf_flushes      = flush_cnt;
`else
  assign bus.perf_stall_cycles = '0;
  assign bus.perf_flushes      = '0;
`endif

endmodule
